// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: shares a single asynchronous 16-bit SRAM between instruction fetch and
// MEM-stage data accesses. Fetch uses the SRAM in every cycle that no data access owns it.
// A data request seen in FETCH stalls the pipeline until the access reaches DONE.
//
// Parameters
//   NOP_INST : instruction word returned when no fetch is served
//   RD_WAIT  : cycles spent in DREAD (1..4)
//   ADDR_HI  : upper two SRAM address bits
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   inst_addr_i, inst_ce_i  : fetch address and enable
//   inst_data_o             : fetched instruction (combinational from the SRAM bus)
//   data_addr_i             : data address
//   data_re_i, data_we_i    : data read / write requests (both set is a write)
//   data_wdata_i            : write data
//   data_rdata_o            : registered read data
//   stall_req_o             : pipeline stall request
//   ram_addr_o, ram_data_io : SRAM address and bidirectional data bus
//   ram_ce_n_o, ram_oe_n_o, ram_we_n_o : active-low SRAM strobes
module mem_bus_ctrl #(
    parameter logic [15:0] NOP_INST = 16'h0800,
    parameter int unsigned RD_WAIT  = 1,
    parameter logic [1:0]  ADDR_HI  = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_addr_i,
    input  logic        inst_ce_i,
    output logic [15:0] inst_data_o,
    input  logic [15:0] data_addr_i,
    input  logic        data_re_i,
    input  logic        data_we_i,
    input  logic [15:0] data_wdata_i,
    output logic [15:0] data_rdata_o,
    output logic        stall_req_o,
    output logic [17:0] ram_addr_o,
    inout  wire  [15:0] ram_data_io,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o
);

    typedef enum logic [2:0] {
        StFetch,
        StDread,
        StDwr1,
        StDwr2,
        StDone
    } state_e;

    // Count value of the final DREAD cycle.
    localparam logic [2:0] RdLast = 3'(RD_WAIT - 1);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] rdata_q;

    logic        fetch_en;
    logic        bus_drive;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            cnt_q   <= 3'd0;
            rdata_q <= 16'h0000;
        end else begin
            case (state_q)
                StFetch: begin
                    cnt_q <= 3'd0;
                    // A simultaneous read and write is handled as a write.
                    if (data_we_i) begin
                        state_q <= StDwr1;
                    end else if (data_re_i) begin
                        state_q <= StDread;
                    end
                end
                StDread: begin
                    if (cnt_q == RdLast) begin
                        rdata_q <= ram_data_io;
                        cnt_q   <= 3'd0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StDwr1:  state_q <= StDwr2;
                StDwr2:  state_q <= StDone;
                // DONE never starts a data access; a pending request is taken up in FETCH.
                StDone:  state_q <= StFetch;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Gating with rst releases every strobe and the bus as soon as reset asserts,
    // without waiting for the state register to settle.
    assign fetch_en  = rst && inst_ce_i && (state_q == StFetch || state_q == StDone);
    assign bus_drive = rst && (state_q == StDwr1 || state_q == StDwr2);

    assign ram_data_io  = bus_drive ? data_wdata_i : 16'hzzzz;
    assign inst_data_o  = fetch_en ? ram_data_io : NOP_INST;
    assign data_rdata_o = rdata_q;

    always_comb begin
        ram_addr_o  = {ADDR_HI, inst_addr_i};
        ram_ce_n_o  = 1'b1;
        ram_oe_n_o  = 1'b1;
        ram_we_n_o  = 1'b1;
        stall_req_o = 1'b0;
        if (rst) begin
            case (state_q)
                StFetch, StDone: begin
                    if (inst_ce_i) begin
                        ram_ce_n_o = 1'b0;
                        ram_oe_n_o = 1'b0;
                    end
                    if (state_q == StFetch) begin
                        stall_req_o = data_re_i | data_we_i;
                    end
                end
                StDread: begin
                    ram_addr_o  = {ADDR_HI, data_addr_i};
                    ram_ce_n_o  = 1'b0;
                    ram_oe_n_o  = 1'b0;
                    stall_req_o = 1'b1;
                end
                StDwr1: begin
                    ram_addr_o  = {ADDR_HI, data_addr_i};
                    ram_ce_n_o  = 1'b0;
                    ram_we_n_o  = 1'b0;
                    stall_req_o = 1'b1;
                end
                StDwr2: begin
                    // Hold cycle: address and data stay valid after we_n rises.
                    ram_addr_o  = {ADDR_HI, data_addr_i};
                    ram_ce_n_o  = 1'b0;
                    stall_req_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [15:0] inst_addr;
    logic [15:0] data_addr;
    logic [15:0] wdata;
    logic        inst_ce;
    logic        data_re;
    logic        data_we;

    int checks = 0;
    int errors = 0;

    // Requests reach only the selected instance so the other one stays idle in FETCH.
    logic a_re, a_we, b_re, b_we;
    assign a_re = data_re & ~sel;
    assign a_we = data_we & ~sel;
    assign b_re = data_re & sel;
    assign b_we = data_we & sel;

    logic [15:0] a_inst, a_rdata, b_inst, b_rdata;
    logic        a_stall, a_ce_n, a_oe_n, a_we_n;
    logic        b_stall, b_ce_n, b_oe_n, b_we_n;
    logic [17:0] a_addr, b_addr;
    wire  [15:0] a_bus, b_bus;

    mem_bus_ctrl #(.NOP_INST(NOP), .RD_WAIT(1), .ADDR_HI(2'b00)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr),
        .inst_ce_i   (inst_ce),
        .inst_data_o (a_inst),
        .data_addr_i (data_addr),
        .data_re_i   (a_re),
        .data_we_i   (a_we),
        .data_wdata_i(wdata),
        .data_rdata_o(a_rdata),
        .stall_req_o (a_stall),
        .ram_addr_o  (a_addr),
        .ram_data_io (a_bus),
        .ram_ce_n_o  (a_ce_n),
        .ram_oe_n_o  (a_oe_n),
        .ram_we_n_o  (a_we_n)
    );

    mem_bus_ctrl #(.NOP_INST(NOP), .RD_WAIT(3), .ADDR_HI(2'b01)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr),
        .inst_ce_i   (inst_ce),
        .inst_data_o (b_inst),
        .data_addr_i (data_addr),
        .data_re_i   (b_re),
        .data_we_i   (b_we),
        .data_wdata_i(wdata),
        .data_rdata_o(b_rdata),
        .stall_req_o (b_stall),
        .ram_addr_o  (b_addr),
        .ram_data_io (b_bus),
        .ram_ce_n_o  (b_ce_n),
        .ram_oe_n_o  (b_oe_n),
        .ram_we_n_o  (b_we_n)
    );

    // Power-up contents of both SRAMs.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0004) return 16'h4901;
        if (a == 16'h8000) return 16'hBEEF;
        return (a * 16'd40503) ^ 16'h5A3C;
    endfunction

    // SRAM models: drive on ce_n=0/oe_n=0/we_n=1, capture writes at the clock edge.
    bit          wr_a [65536];
    bit          wr_b [65536];
    logic [15:0] st_a [65536];
    logic [15:0] st_b [65536];

    assign a_bus = (!a_ce_n && !a_oe_n && a_we_n) ?
                   (wr_a[a_addr[15:0]] ? st_a[a_addr[15:0]] : init_val(a_addr[15:0])) : 16'hzzzz;
    assign b_bus = (!b_ce_n && !b_oe_n && b_we_n) ?
                   (wr_b[b_addr[15:0]] ? st_b[b_addr[15:0]] : init_val(b_addr[15:0])) : 16'hzzzz;

    always @(posedge clk) begin
        if (rst && !a_ce_n && !a_we_n) begin
            wr_a[a_addr[15:0]] <= 1'b1;
            st_a[a_addr[15:0]] <= a_bus;
        end
        if (rst && !b_ce_n && !b_we_n) begin
            wr_b[b_addr[15:0]] <= 1'b1;
            st_b[b_addr[15:0]] <= b_bus;
        end
    end

    // Observed signals of the instance under test.
    logic [15:0] o_inst, o_rdata, o_bus;
    logic [17:0] o_addr;
    logic        o_stall, o_ce_n, o_oe_n, o_we_n;
    assign o_inst  = sel ? b_inst  : a_inst;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_bus   = sel ? b_bus   : a_bus;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_stall = sel ? b_stall : a_stall;
    assign o_ce_n  = sel ? b_ce_n  : a_ce_n;
    assign o_oe_n  = sel ? b_oe_n  : a_oe_n;
    assign o_we_n  = sel ? b_we_n  : a_we_n;

    // Reference model: expected memory contents and last read word per instance.
    logic [15:0] ref_a [logic [15:0]];
    logic [15:0] ref_b [logic [15:0]];
    logic [15:0] exp_rdata [2];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (sel) return ref_b.exists(a) ? ref_b[a] : init_val(a);
        return ref_a.exists(a) ? ref_a[a] : init_val(a);
    endfunction

    function automatic int rd_wait();
        return sel ? 3 : 1;
    endfunction

    function automatic logic [1:0] addr_hi();
        return sel ? 2'b01 : 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MEM-stage operation, started just after a rising edge while in FETCH.
    // With b2b set, the next read request is raised during DONE and left in place.
    task automatic access(input logic re_v, input logic we_v, input logic [15:0] da,
                          input logic [15:0] wd, input logic ce_v, input logic [15:0] ia,
                          input logic b2b, input logic [15:0] nxt);
        int          n_stall;
        int          n_wen;
        int          n_wbus;
        int          exp_stall;
        logic        is_wr;
        logic        is_rd;
        logic [15:0] fexp;
        is_wr     = we_v;
        is_rd     = re_v & ~we_v;
        exp_stall = is_wr ? 3 : (is_rd ? rd_wait() + 1 : 0);
        fexp      = ce_v ? ref_rd(ia) : NOP;
        data_re   = re_v;
        data_we   = we_v;
        data_addr = da;
        wdata     = wd;
        inst_ce   = ce_v;
        inst_addr = ia;
        n_stall   = 0;
        n_wen     = 0;
        n_wbus    = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0 || !o_stall) begin
                check("inst_data", 32'(o_inst), 32'(fexp));
                if (ce_v) check("fetch_addr", 32'(o_addr), 32'({addr_hi(), ia}));
            end else begin
                check("inst_nop", 32'(o_inst), 32'(NOP));
                check("data_addr", 32'(o_addr), 32'({addr_hi(), da}));
            end
            if (!o_ce_n && !o_oe_n) check("rd_bus", 32'(o_bus), 32'(ref_rd(o_addr[15:0])));
            if (o_stall) n_stall++;
            if (!o_we_n) n_wen++;
            if (!o_ce_n && o_oe_n && o_bus === wd) n_wbus++;
            if (!o_stall) break;
            @(posedge clk);
            #1;
        end
        check("stall_cycles", 32'(n_stall), 32'(exp_stall));
        check("we_n_low_cycles", 32'(n_wen), is_wr ? 32'd1 : 32'd0);
        check("wr_bus_cycles", 32'(n_wbus), is_wr ? 32'd2 : 32'd0);
        if (is_rd) exp_rdata[sel] = ref_rd(da);
        if (is_wr) begin
            if (sel) ref_b[da] = wd;
            else ref_a[da] = wd;
        end
        check("rdata", 32'(o_rdata), 32'(exp_rdata[sel]));
        if (b2b) begin
            data_we   = 1'b0;
            data_re   = 1'b1;
            data_addr = nxt;
            #1;
            check("done_ignores_req", 32'(o_stall), 32'd0);
            check("done_no_write", 32'(o_we_n), 32'd1);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            data_re = 1'b0;
            data_we = 1'b0;
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] da;
        logic [15:0] ia;
        int          kind;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;

        // Reset outputs, with a fetch and a read request already present.
        rst       = 1'b0;
        sel       = 1'b0;
        inst_ce   = 1'b1;
        inst_addr = 16'h0004;
        data_re   = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h0000;
        wdata     = 16'h0000;
        #3;
        check("rst_ce_n", 32'(o_ce_n), 32'd1);
        check("rst_oe_n", 32'(o_oe_n), 32'd1);
        check("rst_we_n", 32'(o_we_n), 32'd1);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_inst_nop", 32'(o_inst), 32'(NOP));
        check("rst_rdata", 32'(o_rdata), 32'd0);
        data_re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fetch of 16'h4901 from address 4.
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0);
        // Read with RD_WAIT=1.
        access(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0);
        check("read_beef", 32'(o_rdata), 32'h0000BEEF);
        // Write, then read it back.
        access(1'b0, 1'b1, 16'h8002, 16'h1234, 1'b1, 16'h0030, 1'b0, 16'h0);
        access(1'b1, 1'b0, 16'h8002, 16'h0000, 1'b0, 16'h0030, 1'b0, 16'h0);
        check("readback_1234", 32'(o_rdata), 32'h00001234);
        // Back-to-back write then read, read raised during DONE.
        access(1'b0, 1'b1, 16'h8006, 16'hABCD, 1'b1, 16'h0020, 1'b1, 16'h8006);
        access(1'b1, 1'b0, 16'h8006, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h0);
        check("b2b_read", 32'(o_rdata), 32'h0000ABCD);
        // Top address is ordinary memory.
        access(1'b0, 1'b1, 16'hFFFF, 16'h6C6C, 1'b0, 16'h0000, 1'b0, 16'h0);
        access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0);

        // Reset asserted in the middle of a write.
        data_we   = 1'b1;
        data_addr = 16'h8004;
        wdata     = 16'h7777;
        inst_addr = 16'h0010;
        @(posedge clk);
        #1;
        check("dwr1_we_low", 32'(o_we_n), 32'd0);
        check("dwr1_drives", 32'(o_bus === 16'h7777), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("midwr_rst_we_n", 32'(o_we_n), 32'd1);
        check("midwr_rst_bus", 32'(o_bus === 16'h7777), 32'd0);
        check("midwr_rst_ce_n", 32'(o_ce_n), 32'd1);
        check("midwr_rst_stall", 32'(o_stall), 32'd0);
        check("midwr_rst_rdata", 32'(o_rdata), 32'd0);
        data_we = 1'b0;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0);
        // Abandoned write must not have reached memory.
        access(1'b1, 1'b0, 16'h8004, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0);

        // RD_WAIT=3 instance: read, then re+we taken as a write, then a 4-cycle read.
        sel = 1'b1;
        access(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0);
        access(1'b1, 1'b1, 16'h8010, 16'h5A5A, 1'b1, 16'h0008, 1'b0, 16'h0);
        check("both_keeps_rdata", 32'(o_rdata), 32'h0000BEEF);
        access(1'b1, 1'b0, 16'h8010, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0);
        check("rw3_readback", 32'(o_rdata), 32'h00005A5A);

        // Random operation mix on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 30; i++) begin
                kind = $urandom_range(0, 3);
                da   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h8000 + 16'($urandom_range(0, 15));
                ia   = 16'($urandom_range(0, 255));
                access(kind == 1 || kind == 3, kind >= 2, da, 16'($urandom()),
                       1'($urandom_range(0, 1)), ia, 1'b0, 16'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter NOP_INST, default 16'h0800, the instruction word returned to fetch when no fetch is served.
REQ-002 SHALL have parameter RD_WAIT, default 1, the number of cycles spent in DREAD; legal range is 1..4.
REQ-003 SHALL have parameter ADDR_HI, default 2'b00, the upper two SRAM address bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port inst_addr_i, input, 16 bits: fetch address from the PC.
REQ-007 SHALL have port inst_ce_i, input, 1 bit: fetch enable.
REQ-008 SHALL have port inst_data_o, output, 16 bits: fetched instruction, consumed by the CPU's instruction input.
REQ-009 SHALL have port data_addr_i, input, 16 bits: MEM-stage data address.
REQ-010 SHALL have port data_re_i, input, 1 bit: data read request.
REQ-011 SHALL have port data_we_i, input, 1 bit: data write request.
REQ-012 SHALL have port data_wdata_i, input, 16 bits: data to be written.
REQ-013 SHALL have port data_rdata_o, output, 16 bits: registered read data.
REQ-014 SHALL have port stall_req_o, output, 1 bit: pipeline stall request, feeding the ctrl stall input from MEM.
REQ-015 SHALL have port ram_addr_o, output, 18 bits: SRAM address, always {ADDR_HI, 16-bit address}.
REQ-016 SHALL have port ram_data_io, inout, 16 bits: SRAM data bus.
REQ-017 SHALL have ports ram_ce_n_o, ram_oe_n_o and ram_we_n_o, output, 1 bit each: active-low SRAM strobes.

Function
REQ-018 SHALL implement the states FETCH, DREAD, DWR1, DWR2 and DONE, with exactly one SRAM access per cycle.
REQ-019 SHALL, in FETCH and DONE with inst_ce_i=1, drive ram_addr_o={ADDR_HI,inst_addr_i}, ce_n=0, oe_n=0, we_n=1, bus Z, and pass inst_data_o=ram_data_io combinationally in the same cycle.
REQ-020 SHALL, in FETCH or DONE with inst_ce_i=0, drive ce_n=1 and oe_n=1 and output inst_data_o=NOP_INST.
REQ-021 SHALL, in DREAD, DWR1 and DWR2, output inst_data_o=NOP_INST and drive no fetch address.
REQ-022 SHALL, in FETCH, set stall_req_o=1 combinationally when data_we_i or data_re_i=1, going next to DWR1 if data_we_i=1, else to DREAD.
REQ-023 SHALL treat simultaneous data_re_i and data_we_i as a write; data_rdata_o is left unchanged in that case.
REQ-024 SHALL, in DREAD, drive {ADDR_HI,data_addr_i}, ce_n=0, oe_n=0, we_n=1, bus Z, and count cycles with a 3-bit counter.
REQ-025 SHALL, on the last DREAD cycle (count==RD_WAIT-1), latch ram_data_io into data_rdata_o and go to DONE.
REQ-026 SHALL, in DWR1, drive the address, ce_n=0, oe_n=1, we_n=0, and ram_data_io=data_wdata_i.
REQ-027 SHALL, in DWR2, keep the address and data driven with we_n=1 (hold cycle), then go to DONE.
REQ-028 SHALL hold stall_req_o=1 throughout DREAD, DWR1 and DWR2, and set stall_req_o=0 in DONE.
REQ-029 SHALL make DONE always go to FETCH and never start a data access, even if a request is still asserted.
REQ-030 SHALL give latencies from request to DONE of RD_WAIT+1 cycles for a read and 3 cycles for a write.
REQ-031 SHALL stall again when a request is present in the FETCH cycle that follows DONE, which handles back-to-back accesses.
REQ-032 SHALL drive ram_data_io only in DWR1 and DWR2, and never drive it while oe_n=0.
REQ-033 SHALL treat address 16'hFFFF as ordinary memory, with no wrap-around special case.

Reset
REQ-034 SHALL, while rst=0, asynchronously force: state=FETCH, counter=0, ce_n=oe_n=we_n=1, bus Z, stall_req_o=0, data_rdata_o=16'h0000, inst_data_o=NOP_INST.
REQ-035 SHALL, on reset asserted mid-write, raise we_n immediately and abandon the access without completing it.
REQ-036 SHALL resume in FETCH on the first rising clk edge after rst deasserts.

Verification
REQ-037 SHALL verify reset: rst=0 while in DWR1 -> we_n=1 and bus Z with no clock edge; after release, state FETCH and stall_req_o=0.
REQ-038 SHALL verify fetch: inst_ce_i=1, inst_addr_i=16'h0004, SRAM word 16'h4901 -> ram_addr_o=18'h00004, inst_data_o=16'h4901 in the same cycle, stall_req_o=0.
REQ-039 SHALL verify a read with RD_WAIT=1: data_re_i=1, address 16'h8000, SRAM word 16'hBEEF -> stall_req_o high 2 cycles, data_rdata_o=16'hBEEF in DONE, inst_data_o=16'h0800 during DREAD.
REQ-040 SHALL verify a write: data_we_i=1, address 16'h8002, data 16'h1234 -> we_n low exactly 1 cycle (DWR1), bus drives 16'h1234 for 2 cycles, stall_req_o high 3 cycles; a read-back returns 16'h1234.
REQ-041 SHALL verify back-to-back: a write then a read in consecutive MEM instructions -> DONE, FETCH (stall_req_o=1), DREAD, DONE, and the bus is never driven while oe_n=0.
REQ-042 SHALL verify RD_WAIT=3 with re and we both asserted -> the write path is taken, data_rdata_o is unchanged, and a later read stalls for 4 cycles.
